// File: rtl/fetch_buffer_pkg.sv
// Shared constants for the IF -> fetch_buffer -> ID boundary.
// Holds the canonical NOP, the reset PC, the default buffer depth and the
// packed width of the IF-to-fetch_buffer bus {fetch_req, fetch_pc}.
package fetch_buffer_pkg;

  localparam int unsigned XLEN        = 64;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [63:0] RESET_PC    = 64'h7fff_fffc;
  localparam int unsigned FB_DEPTH    = 4;
  localparam int unsigned IF_FB_BUS_W = 1 + XLEN;       // {fetch_req, fetch_pc}

  // Pick the 32-bit instruction out of a 64-bit SRAM word using PC bit 2.
  function automatic logic [31:0] sel_word(input logic [63:0] rdata, input logic hi);
    return hi ? rdata[63:32] : rdata[31:0];
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Bundle of the fetch_buffer data-path signals.
//   master: pipeline side (IF request, SRAM data, EX redirect, ID ready)
//   slave : fetch_buffer (drives the ID-facing head entry and the IF stall)
interface fetch_buffer_if #(
  parameter int unsigned PC_W = fetch_buffer_pkg::XLEN
) ();

  logic            br_e;             // redirect/flush from EX
  logic            fetch_req;        // read of fetch_pc issued this cycle
  logic [PC_W-1:0] fetch_pc;
  logic [63:0]     inst_sram_rdata;  // valid the cycle after fetch_req
  logic            id_ready;
  logic            id_valid;
  logic [PC_W-1:0] id_pc;
  logic [31:0]     id_inst;
  logic            stallreq_fb;

  modport master (
    output br_e, fetch_req, fetch_pc, inst_sram_rdata, id_ready,
    input  id_valid, id_pc, id_inst, stallreq_fb
  );

  modport slave (
    input  br_e, fetch_req, fetch_pc, inst_sram_rdata, id_ready,
    output id_valid, id_pc, id_inst, stallreq_fb
  );

endinterface

// File: rtl/fetch_buffer_sync_fifo.sv
// Synchronous FIFO with clear and an occupancy count.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clear        : drop all entries (wins over push/pop)
//   i_push/i_wdata : write an entry at the tail
//   i_pop          : retire the head entry
//   o_rdata        : head entry (undefined contents when empty)
//   o_count        : number of stored entries, 0..Depth
module fetch_buffer_sync_fifo #(
  parameter int unsigned Width = 96,
  parameter int unsigned Depth = 4   // power of two, >= 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [Width-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [Width-1:0]           o_rdata,
  output logic [$clog2(Depth):0]     o_count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [CntW-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  always_comb begin
    w_full    = (r_count == CntW'(Depth));
    w_empty   = (r_count == '0);
    w_do_push = i_push & ~w_full;
    w_do_pop  = i_pop & ~w_empty;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer between IF and ID.
// Registers each issued fetch PC for one cycle so it lines up with the
// synchronous SRAM read data, selects the 32-bit word, and queues {pc, inst}
// pairs for ID over a valid/ready handshake.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   io_fb (slave)  : br_e, fetch_req, fetch_pc, inst_sram_rdata, id_ready in;
//                    id_valid, id_pc, id_inst, stallreq_fb out
module fetch_buffer #(
  parameter int unsigned DEPTH    = fetch_buffer_pkg::FB_DEPTH,
  parameter int unsigned PC_W     = fetch_buffer_pkg::XLEN,
  parameter logic [31:0] NOP_INST = fetch_buffer_pkg::NOP_INST
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fetch_buffer_if.slave io_fb
);
  import fetch_buffer_pkg::*;

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned EntryW = PC_W + 32;

  logic            r_resp_v;
  logic [PC_W-1:0] r_resp_pc;

  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [31:0]       w_inst;
  logic [EntryW-1:0] w_head;
  logic [CntW-1:0]   w_count;
  logic [CntW:0]     w_occ;

  // Response stage: a redirect in the issue cycle kills the read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_resp_v  <= 1'b0;
      r_resp_pc <= '0;
    end else begin
      r_resp_v  <= io_fb.fetch_req & ~io_fb.br_e;
      r_resp_pc <= io_fb.fetch_pc;
    end
  end

  always_comb begin
    w_inst  = sel_word(io_fb.inst_sram_rdata, r_resp_pc[2]);
    w_valid = (w_count != '0);
    w_push  = r_resp_v & ~io_fb.br_e;
    w_pop   = w_valid & io_fb.id_ready & ~io_fb.br_e;
    // Ignores same-cycle pops so the stall is a function of registered state.
    w_occ   = {1'b0, w_count} + (CntW + 1)'(r_resp_v);
  end

  fetch_buffer_sync_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (io_fb.br_e),
    .i_push  (w_push),
    .i_wdata ({r_resp_pc, w_inst}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign io_fb.id_valid    = w_valid;
  assign io_fb.id_pc       = w_valid ? w_head[EntryW-1:32] : '0;
  assign io_fb.id_inst     = w_valid ? w_head[31:0] : NOP_INST;
  assign io_fb.stallreq_fb = (w_occ >= (CntW + 1)'(DEPTH));

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_buffer_if #(.PC_W(PC_W)) fb ();

  fetch_buffer #(
    .DEPTH    (DEPTH),
    .PC_W     (PC_W),
    .NOP_INST (NOP_INST)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_fb   (fb)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of fetched pairs plus one in-flight read.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        mq[$];
  bit          m_infl;
  logic [63:0] m_infl_pc;
  bit          m_known = 1'b0;

  typedef struct {
    bit          chk;
    logic        rst_n;
    logic        br_e;
    logic        req;
    logic [63:0] pc;
    logic [63:0] rdata;
    logic        ready;
    logic        v;
    logic [63:0] epc;
    logic [31:0] einst;
    logic        stall;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit          ev;
    logic [63:0] epc;
    logic [31:0] ei;
    if (!m_known) return;
    ev  = (mq.size() != 0);
    epc = ev ? mq[0].pc : 64'h0;
    ei  = ev ? mq[0].inst : NOP_INST;
    check("m_valid", {63'b0, fb.id_valid}, {63'b0, ev});
    check("m_pc", fb.id_pc, epc);
    check("m_inst", {32'b0, fb.id_inst}, {32'b0, ei});
    check("m_stall", {63'b0, fb.stallreq_fb},
          {63'b0, (mq.size() + int'(m_infl)) >= DEPTH});
  endtask

  // Compare, advance the model with the current inputs, then clock.
  task automatic step();
    ent_t e;
    model_check();
    check("no_push_when_full", {63'b0, dut.w_push && (dut.w_count == DEPTH)}, 64'h0);
    if (!rst_n) begin
      mq.delete();
      m_infl  = 1'b0;
      m_known = 1'b1;
    end else if (fb.br_e) begin
      mq.delete();
      m_infl = 1'b0;
    end else begin
      if (mq.size() != 0 && fb.id_ready) void'(mq.pop_front());
      if (m_infl) begin
        e.pc   = m_infl_pc;
        e.inst = m_infl_pc[2] ? fb.inst_sram_rdata[63:32] : fb.inst_sram_rdata[31:0];
        mq.push_back(e);
      end
      m_infl    = fb.fetch_req;
      m_infl_pc = fb.fetch_pc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit chk, input logic rs, input logic br, input logic rq,
                     input logic [63:0] pc, input logic [63:0] rd, input logic rdy,
                     input logic v, input logic [63:0] epc, input logic [31:0] ei,
                     input logic st);
    vec_t r;
    r.chk = chk; r.rst_n = rs; r.br_e = br; r.req = rq; r.pc = pc; r.rdata = rd;
    r.ready = rdy; r.v = v; r.epc = epc; r.einst = ei; r.stall = st;
    vt.push_back(r);
  endtask

  function automatic logic [63:0] rd_for(input logic [63:0] a);
    return {(a[31:0] | 32'h4) ^ 32'hF0F0_0000, (a[31:0] & ~32'h4) ^ 32'hF0F0_0000};
  endfunction

  task automatic drive(input logic rs, input logic br, input logic rq, input logic [63:0] pc,
                       input logic [63:0] rd, input logic rdy);
    rst_n = rs; fb.br_e = br; fb.fetch_req = rq; fb.fetch_pc = pc;
    fb.inst_sram_rdata = rd; fb.id_ready = rdy;
  endtask

  initial begin
    logic [63:0] pc;
    logic [63:0] last_pc;
    logic [63:0] exp_pc;
    logic        rq;
    logic        br;

    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);

    //  chk rst br rq pc              rdata                    rdy | v epc            inst          st
    add(0, 0, 0, 0, 64'h0,          64'h0,                   0,   0, 64'h0,          32'h13,       0);
    add(1, 1, 0, 1, 64'h8000_0000,  64'h0,                   0,   0, 64'h0,          32'h13,       0);
    add(1, 1, 0, 0, 64'h0,          64'h1111_1111_0000_0093, 0,   0, 64'h0,          32'h13,       0);
    add(1, 1, 0, 0, 64'h0,          64'h0,                   1,   1, 64'h8000_0000,  32'h0000_0093, 0);
    add(1, 1, 0, 1, 64'h8000_0004,  64'h0,                   1,   0, 64'h0,          32'h13,       0);
    add(1, 1, 0, 0, 64'h0,          64'h0010_0113_dead_beef, 0,   0, 64'h0,          32'h13,       0);
    add(1, 1, 0, 0, 64'h0,          64'h0,                   1,   1, 64'h8000_0004,  32'h0010_0113, 0);
    // fill with ID stalled, fetch only while stallreq_fb is low
    add(1, 1, 0, 1, 64'h8000_0000,  64'h0,                   0,   0, 64'h0,          32'h13,       0);
    add(1, 1, 0, 1, 64'h8000_0004,  64'hB000_0004_A000_0000, 0,   0, 64'h0,          32'h13,       0);
    add(1, 1, 0, 1, 64'h8000_0008,  64'hB000_0004_A000_0000, 0,   1, 64'h8000_0000,  32'hA000_0000, 0);
    add(1, 1, 0, 1, 64'h8000_000C,  64'hB000_000C_A000_0008, 0,   1, 64'h8000_0000,  32'hA000_0000, 0);
    add(1, 1, 0, 0, 64'h0,          64'hB000_000C_A000_0008, 0,   1, 64'h8000_0000,  32'hA000_0000, 1);
    add(1, 1, 0, 0, 64'h0,          64'h0,                   1,   1, 64'h8000_0000,  32'hA000_0000, 1);
    add(1, 1, 0, 0, 64'h0,          64'h0,                   1,   1, 64'h8000_0004,  32'hB000_0004, 0);
    add(1, 1, 0, 0, 64'h0,          64'h0,                   1,   1, 64'h8000_0008,  32'hA000_0008, 0);
    add(1, 1, 0, 0, 64'h0,          64'h0,                   1,   1, 64'h8000_000C,  32'hB000_000C, 0);
    // flush with one queued and one in flight
    add(1, 1, 0, 1, 64'h8000_0000,  64'h0,                   0,   0, 64'h0,          32'h13,       0);
    add(1, 1, 0, 1, 64'h8000_0004,  64'hB000_0004_A000_0000, 0,   0, 64'h0,          32'h13,       0);
    add(1, 1, 1, 1, 64'h8000_0008,  64'hB000_0004_A000_0000, 0,   1, 64'h8000_0000,  32'hA000_0000, 0);
    add(1, 1, 0, 1, 64'h8000_0100,  64'hFFFF_FFFF_FFFF_FFFF, 0,   0, 64'h0,          32'h13,       0);
    add(1, 1, 0, 0, 64'h0,          64'h2222_2222_0000_0513, 0,   0, 64'h0,          32'h13,       0);
    add(1, 1, 0, 0, 64'h0,          64'h0,                   1,   1, 64'h8000_0100,  32'h0000_0513, 0);
    add(1, 1, 0, 0, 64'h0,          64'h0,                   0,   0, 64'h0,          32'h13,       0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst_n, vt[i].br_e, vt[i].req, vt[i].pc, vt[i].rdata, vt[i].ready);
      if (vt[i].chk) begin
        check($sformatf("vec%0d_valid", i), {63'b0, fb.id_valid}, {63'b0, vt[i].v});
        check($sformatf("vec%0d_pc", i), fb.id_pc, vt[i].epc);
        check($sformatf("vec%0d_inst", i), {32'b0, fb.id_inst}, {32'b0, vt[i].einst});
        check($sformatf("vec%0d_stall", i), {63'b0, fb.stallreq_fb}, {63'b0, vt[i].stall});
      end
      step();
    end

    // Streaming at count=2: one push and one pop every cycle.
    pc      = 64'h8000_0200;
    last_pc = 64'h0;
    exp_pc  = 64'h8000_0200;
    for (int c = 0; c < 13; c++) begin
      drive(1'b1, 1'b0, 1'b1, pc, rd_for(last_pc), c >= 3);
      if (c >= 3) begin
        check("stream_valid", {63'b0, fb.id_valid}, 64'h1);
        check("stream_pc", fb.id_pc, exp_pc);
        check("stream_inst", {32'b0, fb.id_inst}, {32'b0, exp_pc[31:0] ^ 32'hF0F0_0000});
        check("stream_stall", {63'b0, fb.stallreq_fb}, 64'h0);
        exp_pc += 64'd4;
      end
      step();
      last_pc = pc;
      pc += 64'd4;
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 1'b0, 64'h0, rd_for(last_pc), 1'b1);
      step();
    end

    // Reset while count=3 and a read is in flight.
    pc = 64'h8000_0300;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 1'b1, pc, rd_for(last_pc), 1'b0);
      step();
      last_pc = pc;
      pc += 64'd4;
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0, rd_for(last_pc), 1'b0);
    check("pre_rst_stall", {63'b0, fb.stallreq_fb}, 64'h1);
    check("pre_rst_pc", fb.id_pc, 64'h8000_0300);
    step();
    check("rst_valid", {63'b0, fb.id_valid}, 64'h0);
    check("rst_pc", fb.id_pc, 64'h0);
    check("rst_inst", {32'b0, fb.id_inst}, {32'b0, NOP_INST});
    check("rst_stall", {63'b0, fb.stallreq_fb}, 64'h0);
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 1'b0, 64'h0, rd_for(last_pc), 1'b0);
      step();
      check("post_rst_empty", {63'b0, fb.id_valid}, 64'h0);
    end

    // Randomised traffic against the model.
    pc = 64'h8000_0000;
    for (int c = 0; c < 3000; c++) begin
      br = ($urandom_range(0, 15) == 0);
      rq = ((mq.size() + int'(m_infl)) < DEPTH) && ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 199) != 0, br, rq, pc, {$urandom, $urandom},
            $urandom_range(0, 2) != 0);
      step();
      if (br) pc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_fffc)};
      else if (rq) pc += 64'd4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
